// File: rtl/multi_alarm_clock_pkg.sv
// Shared definitions for the multi-alarm clock: FSM encoding, BCD field
// positions and BCD helper functions.
package multi_alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  // Field offsets inside the 24-bit time word {hh, mm, ss}
  localparam int HH_LSB = 16;
  localparam int MM_LSB = 8;
  localparam int SS_LSB = 0;

  // Field offsets inside the 16-bit alarm word {hh, mm}
  localparam int AL_HH_LSB = 8;
  localparam int AL_MM_LSB = 0;

  localparam int HH_MAX = 23;
  localparam int MM_MAX = 59;
  localparam int SS_MAX = 59;

  // True when both nibbles are decimal digits and the pair is <= max_val
  function automatic logic bcd_in_range(input logic [7:0] pair, input int max_val);
    int tens;
    int ones;
    tens = int'(pair[7:4]);
    ones = int'(pair[3:0]);
    return (tens <= 9) && (ones <= 9) && ((tens * 10 + ones) <= max_val);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int bcd_to_bin(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

endpackage

// File: rtl/multi_alarm_clock_bcd_mod_counter.sv
// Two-digit BCD counter with parametrised modulus, synchronous load and a
// combinational carry that fires on the increment that wraps to 00.
module bcd_mod_counter
  import multi_alarm_clock_pkg::*;
#(
  parameter int MOD = 60
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] val,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = bin_to_bcd(MOD - 1);

  logic [7:0] val_reg;
  logic [7:0] val_next;
  logic       at_max;

  assign at_max = (val_reg == MAX_BCD);
  assign carry  = inc && !load && at_max;
  assign val    = val_reg;

  // Next value: load has priority over increment; digit-wise BCD increment
  always_comb begin
    val_next = val_reg;
    if (load) begin
      val_next = load_val;
    end else if (inc) begin
      if (at_max) begin
        val_next = 8'h00;
      end else if (val_reg[3:0] == 4'd9) begin
        val_next = {val_reg[7:4] + 4'd1, 4'd0};
      end else begin
        val_next = {val_reg[7:4], val_reg[3:0] + 4'd1};
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_reg <= 8'h00;
    end else begin
      val_reg <= val_next;
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// Real-time clock with N independent alarm channels, ring/snooze handling,
// 12/24 h display conversion and an hourly chime.
module multi_alarm_clock
  import multi_alarm_clock_pkg::*;
#(
  parameter int CLK_DIV    = 50_000_000,
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [23:0]   set_time,
  input  logic          al_wr,
  input  logic [IW-1:0] al_idx,
  input  logic [15:0]   al_time,
  input  logic          al_en,
  input  logic          snooze,
  input  logic          stop,
  input  logic          mode12,
  input  logic          chime_en,
  output logic [23:0]   time_bcd,
  output logic [7:0]    disp_hh,
  output logic          pm,
  output logic          sec_tick,
  output logic          ringing,
  output logic [IW-1:0] ring_ch,
  output logic          chime
);

  localparam int PW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SNZ_TICKS   = SNOOZE_MIN * 60;
  localparam int SW          = $clog2(SNZ_TICKS + 1);
  localparam logic [7:0]    RING_LOAD = 8'(RING_SEC);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);

  // ---------------------------------------------------------------- prescaler
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic          presc_wrap;
  logic          set_ok;
  logic          tick;

  assign set_ok = set_en
                && bcd_in_range(set_time[HH_LSB +: 8], HH_MAX)
                && bcd_in_range(set_time[MM_LSB +: 8], MM_MAX)
                && bcd_in_range(set_time[SS_LSB +: 8], SS_MAX);

  assign presc_wrap = (presc_reg == PW'(CLK_DIV - 1));
  // A valid load restarts the second, so it suppresses a coincident tick
  assign tick       = presc_wrap && !set_ok;
  assign sec_tick   = tick;

  // Prescaler next value: cleared by a valid load or on wrap
  always_comb begin
    presc_next = presc_reg + PW'(1);
    if (set_ok || presc_wrap) begin
      presc_next = '0;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  // ---------------------------------------------------------- time counters
  logic [7:0] ss_val;
  logic [7:0] mm_val;
  logic [7:0] hh_val;
  logic       ss_carry;
  logic       mm_carry;
  logic       day_wrap_unused;

  bcd_mod_counter #(.MOD(60)) u_ss (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (set_ok),
    .load_val (set_time[SS_LSB +: 8]),
    .inc      (tick),
    .val      (ss_val),
    .carry    (ss_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_mm (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (set_ok),
    .load_val (set_time[MM_LSB +: 8]),
    .inc      (ss_carry),
    .val      (mm_val),
    .carry    (mm_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hh (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (set_ok),
    .load_val (set_time[HH_LSB +: 8]),
    .inc      (mm_carry),
    .val      (hh_val),
    .carry    (day_wrap_unused)
  );

  assign time_bcd = {hh_val, mm_val, ss_val};

  // ------------------------------------------- match strobe and hourly chime
  logic eval_pending_reg;
  logic chime_reg;

  // Flag the cycle after a tick rolls seconds to 00; pulse chime on the hour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_pending_reg <= 1'b0;
      chime_reg        <= 1'b0;
    end else begin
      eval_pending_reg <= tick && ss_carry;
      chime_reg        <= mm_carry && chime_en;
    end
  end

  assign chime = chime_reg;

  // ----------------------------------------------------------- alarm storage
  logic                    al_ok;
  logic [N_ALARM*16-1:0]   al_time_flat;
  logic [N_ALARM-1:0]      al_en_vec;

  assign al_ok = al_wr
               && bcd_in_range(al_time[AL_HH_LSB +: 8], HH_MAX)
               && bcd_in_range(al_time[AL_MM_LSB +: 8], MM_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < N_ALARM; gi++) begin : g_alarm
      logic [15:0] time_reg;
      logic        en_reg;
      logic        wr_hit;

      // Indices beyond N_ALARM-1 never equal any gi, so they write nothing
      assign wr_hit = al_ok && (al_idx == IW'(gi));

      // Per-channel alarm time and enable
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          time_reg <= 16'h0000;
          en_reg   <= 1'b0;
        end else if (wr_hit) begin
          time_reg <= al_time;
          en_reg   <= al_en;
        end
      end

      assign al_time_flat[gi*16 +: 16] = time_reg;
      assign al_en_vec[gi]             = en_reg;
    end
  endgenerate

  // --------------------------------------------------------------- matching
  logic          match_any;
  logic [IW-1:0] match_idx;
  logic          match_hit;

  // Priority search from the top so the lowest matching index is kept;
  // reads the stored values, so a same-cycle write is not yet visible
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (al_en_vec[i] && (al_time_flat[i*16 +: 16] == {hh_val, mm_val})) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  assign match_hit = eval_pending_reg && match_any;

  // -------------------------------------------------------------------- FSM
  alarm_state_t  state_reg;
  alarm_state_t  state_next;
  logic [7:0]    ring_cnt_reg;
  logic [7:0]    ring_cnt_next;
  logic [SW-1:0] snz_cnt_reg;
  logic [SW-1:0] snz_cnt_next;
  logic [IW-1:0] ring_ch_reg;
  logic [IW-1:0] ring_ch_next;

  // State and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ring_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
      ring_ch_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ring_cnt_reg <= ring_cnt_next;
      snz_cnt_reg  <= snz_cnt_next;
      ring_ch_reg  <= ring_ch_next;
    end
  end

  // Next-state logic; stop is tested before snooze so it wins a tie
  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    ring_ch_next  = ring_ch_reg;
    case (state_reg)
      ST_IDLE: begin
        if (match_hit) begin
          state_next    = ST_RING;
          ring_ch_next  = match_idx;
          ring_cnt_next = RING_LOAD;
        end
      end
      ST_RING: begin
        if (stop) begin
          state_next    = ST_IDLE;
          ring_cnt_next = '0;
        end else if (snooze) begin
          state_next    = ST_SNOOZE;
          ring_cnt_next = '0;
          snz_cnt_next  = SNZ_LOAD;
        end else if (tick) begin
          if (ring_cnt_reg <= 8'd1) begin
            state_next    = ST_IDLE;
            ring_cnt_next = '0;
          end else begin
            ring_cnt_next = ring_cnt_reg - 8'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (stop) begin
          state_next   = ST_IDLE;
          snz_cnt_next = '0;
        end else if (match_hit) begin
          state_next    = ST_RING;
          ring_ch_next  = match_idx;
          ring_cnt_next = RING_LOAD;
          snz_cnt_next  = '0;
        end else if (tick) begin
          if (snz_cnt_reg <= SW'(1)) begin
            state_next    = ST_RING;
            ring_cnt_next = RING_LOAD;
            snz_cnt_next  = '0;
          end else begin
            snz_cnt_next = snz_cnt_reg - SW'(1);
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        ring_cnt_next = '0;
        snz_cnt_next  = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    ringing = (state_reg == ST_RING);
  end

  assign ring_ch = ring_ch_reg;

  // ---------------------------------------------------------------- display
  int hh_bin;

  // 12 h conversion: 00 shows as 12, 13..23 fold to 01..11; pm uses 24 h value
  always_comb begin
    hh_bin  = bcd_to_bin(hh_val);
    disp_hh = hh_val;
    pm      = (hh_bin >= 12);
    if (mode12) begin
      if (hh_bin == 0) begin
        disp_hh = 8'h12;
      end else if (hh_bin > 12) begin
        disp_hh = bin_to_bcd(hh_bin - 12);
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: table of set/display vectors plus
// hand-written ring, snooze, stop and reset sequences.
module tb_multi_alarm_clock;

  localparam int CLK_DIV    = 4;
  localparam int N_ALARM    = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 1;
  localparam int IW         = 2;

  logic          clk;
  logic          rst_n;
  logic          set_en;
  logic [23:0]   set_time;
  logic          al_wr;
  logic [IW-1:0] al_idx;
  logic [15:0]   al_time;
  logic          al_en;
  logic          snooze;
  logic          stop;
  logic          mode12;
  logic          chime_en;
  logic [23:0]   time_bcd;
  logic [7:0]    disp_hh;
  logic          pm;
  logic          sec_tick;
  logic          ringing;
  logic [IW-1:0] ring_ch;
  logic          chime;

  multi_alarm_clock #(
    .CLK_DIV    (CLK_DIV),
    .N_ALARM    (N_ALARM),
    .RING_SEC   (RING_SEC),
    .SNOOZE_MIN (SNOOZE_MIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_time (set_time),
    .al_wr    (al_wr),
    .al_idx   (al_idx),
    .al_time  (al_time),
    .al_en    (al_en),
    .snooze   (snooze),
    .stop     (stop),
    .mode12   (mode12),
    .chime_en (chime_en),
    .time_bcd (time_bcd),
    .disp_hh  (disp_hh),
    .pm       (pm),
    .sec_tick (sec_tick),
    .ringing  (ringing),
    .ring_ch  (ring_ch),
    .chime    (chime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int chime_seen = 0;

  always @(negedge clk) begin
    if (chime === 1'b1) chime_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] set_t;
    logic        m12;
    logic [23:0] exp_time;
    logic [7:0]  exp_hh;
    logic        exp_pm;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_clock(input logic [23:0] t);
    @(posedge clk);
    #1 set_time = t;
    set_en = 1'b1;
    @(posedge clk);
    #1 set_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic al_write(input logic [IW-1:0] idx, input logic [15:0] t, input logic en);
    @(posedge clk);
    #1 al_idx = idx;
    al_time = t;
    al_en = en;
    al_wr = 1'b1;
    @(posedge clk);
    #1 al_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic p);
    @(posedge clk);
    #1 snooze = s;
    stop = p;
    @(posedge clk);
    #1 snooze = 1'b0;
    stop = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; counts sec_tick samples including the current one,
  // then lets the time update and the FSM reaction settle.
  task automatic wait_ticks(input int n);
    int seen = 0;
    int budget = n * CLK_DIV * 2 + 20;
    while (1) begin
      if (sec_tick === 1'b1) seen++;
      if (seen >= n || budget == 0) break;
      @(negedge clk);
      budget--;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;

    vecs[0] = '{24'h001530, 1'b1, 24'h001530, 8'h12, 1'b0};
    vecs[1] = '{24'h134500, 1'b1, 24'h134500, 8'h01, 1'b1};
    vecs[2] = '{24'h240000, 1'b1, 24'h134500, 8'h01, 1'b1};
    vecs[3] = '{24'h120000, 1'b1, 24'h120000, 8'h12, 1'b1};
    vecs[4] = '{24'h235959, 1'b0, 24'h235959, 8'h23, 1'b1};
    vecs[5] = '{24'h1A0000, 1'b0, 24'h235959, 8'h23, 1'b1};
    vecs[6] = '{24'h090507, 1'b1, 24'h090507, 8'h09, 1'b0};
    vecs[7] = '{24'h096000, 1'b1, 24'h090507, 8'h09, 1'b0};
    vecs[8] = '{24'h231000, 1'b1, 24'h231000, 8'h11, 1'b1};

    rst_n = 1'b0; set_en = 1'b0; set_time = '0; al_wr = 1'b0; al_idx = '0;
    al_time = '0; al_en = 1'b0; snooze = 1'b0; stop = 1'b0; mode12 = 1'b0;
    chime_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_time", 32'(time_bcd), 32'h000000);
    chk("rst_disp_hh", 32'(disp_hh), 32'h00);
    chk("rst_pm", 32'(pm), 32'd0);
    chk("rst_sec_tick", 32'(sec_tick), 32'd0);
    chk("rst_ringing", 32'(ringing), 32'd0);
    chk("rst_ring_ch", 32'(ring_ch), 32'd0);
    chk("rst_chime", 32'(chime), 32'd0);
    $display("reset: time=%h ringing=%b ring_ch=%0d", time_bcd, ringing, ring_ch);
    rst_n = 1'b1;

    // Table: set_time validation and 12/24 h display
    for (int i = 0; i < 9; i++) begin
      mode12 = vecs[i].m12;
      set_clock(vecs[i].set_t);
      $display("vec %0d: set=%h mode12=%b time=%h disp_hh=%h pm=%b",
               i, vecs[i].set_t, vecs[i].m12, time_bcd, disp_hh, pm);
      chk($sformatf("vec%0d_time", i), 32'(time_bcd), 32'(vecs[i].exp_time));
      chk($sformatf("vec%0d_disp_hh", i), 32'(disp_hh), 32'(vecs[i].exp_hh));
      chk($sformatf("vec%0d_pm", i), 32'(pm), 32'(vecs[i].exp_pm));
    end
    mode12 = 1'b0;

    // set_en coincident with a tick: load wins, tick suppressed
    set_clock(24'h100000);
    repeat (2) @(negedge clk);
    set_time = 24'h111111;
    set_en = 1'b1;
    @(negedge clk);
    chk("set_wins_tick", 32'(sec_tick), 32'd0);
    @(posedge clk);
    #1 set_en = 1'b0;
    @(negedge clk);
    chk("set_wins_time", 32'(time_bcd), 32'h111111);
    $display("set over tick: time=%h", time_bcd);
    // set_en mid-second clears the prescaler
    @(negedge clk);
    set_time = 24'h123456;
    set_en = 1'b1;
    @(posedge clk);
    #1 set_en = 1'b0;
    @(negedge clk);
    chk("set_mid_time", 32'(time_bcd), 32'h123456);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      n++;
      if (sec_tick === 1'b1) break;
      @(negedge clk);
    end
    chk("presc_cleared_cycles", 32'(n), 32'd4);
    $display("prescaler clear: first tick after %0d cycles", n);

    // Midnight rollover and chime
    chime_en = 1'b1;
    base = chime_seen;
    set_clock(24'h235958);
    wait_ticks(1);
    chk("roll_235959", 32'(time_bcd), 32'h235959);
    wait_ticks(1);
    #1;
    chk("roll_midnight", 32'(time_bcd), 32'h000000);
    chk("chime_once", 32'(chime_seen - base), 32'd1);
    $display("midnight: time=%h chimes=%0d", time_bcd, chime_seen - base);

    // Alarm ch2 07:30, auto-stop after RING_SEC ticks
    al_write(2'd2, 16'h0730, 1'b1);
    set_clock(24'h072959);
    wait_ticks(1);
    chk("ch2_ringing", 32'(ringing), 32'd1);
    chk("ch2_ring_ch", 32'(ring_ch), 32'd2);
    $display("alarm ch2: ringing=%b ring_ch=%0d", ringing, ring_ch);
    wait_ticks(2);
    chk("ch2_still_ringing", 32'(ringing), 32'd1);
    wait_ticks(1);
    chk("ch2_auto_stop", 32'(ringing), 32'd0);
    $display("alarm ch2 auto-stop: ringing=%b", ringing);

    // Channels 1 and 3 at 06:00, invalid overwrite of ch1 ignored, snooze
    chime_en = 1'b0;
    al_write(2'd1, 16'h0600, 1'b1);
    al_write(2'd3, 16'h0600, 1'b1);
    al_write(2'd1, 16'h0660, 1'b0);
    base = chime_seen;
    set_clock(24'h055959);
    wait_ticks(1);
    #1;
    chk("dual_ringing", 32'(ringing), 32'd1);
    chk("dual_lowest_ch", 32'(ring_ch), 32'd1);
    chk("no_chime_disabled", 32'(chime_seen - base), 32'd0);
    $display("dual match: ringing=%b ring_ch=%0d", ringing, ring_ch);
    pulse(1'b1, 1'b0);
    chk("snooze_quiet", 32'(ringing), 32'd0);
    chk("snooze_ring_ch", 32'(ring_ch), 32'd1);
    wait_ticks(SNOOZE_MIN * 60 - 1);
    chk("snooze_not_yet", 32'(ringing), 32'd0);
    wait_ticks(1);
    chk("snooze_rerings", 32'(ringing), 32'd1);
    chk("snooze_rering_ch", 32'(ring_ch), 32'd1);
    $display("snooze expiry: ringing=%b ring_ch=%0d", ringing, ring_ch);
    pulse(1'b0, 1'b1);
    chk("stop_ring", 32'(ringing), 32'd0);

    // New match while snoozing rings with the new channel; set_en keeps state
    set_clock(24'h055959);
    wait_ticks(1);
    pulse(1'b1, 1'b0);
    set_clock(24'h072959);
    chk("set_in_snooze_quiet", 32'(ringing), 32'd0);
    wait_ticks(1);
    chk("snooze_new_match", 32'(ringing), 32'd1);
    chk("snooze_new_ch", 32'(ring_ch), 32'd2);
    $display("match during snooze: ringing=%b ring_ch=%0d", ringing, ring_ch);
    pulse(1'b0, 1'b1);

    // stop and snooze together: stop wins, no re-ring later
    set_clock(24'h055959);
    wait_ticks(1);
    chk("tie_pre_ringing", 32'(ringing), 32'd1);
    pulse(1'b1, 1'b1);
    chk("tie_stop_wins", 32'(ringing), 32'd0);
    wait_ticks(SNOOZE_MIN * 60 + 1);
    chk("tie_no_rering", 32'(ringing), 32'd0);
    $display("stop+snooze: ringing=%b after snooze period", ringing);

    // Reset during SNOOZE
    set_clock(24'h055959);
    wait_ticks(1);
    pulse(1'b1, 1'b0);
    wait_ticks(10);
    rst_n = 1'b0;
    #1;
    chk("rst_snz_time", 32'(time_bcd), 32'h000000);
    chk("rst_snz_ringing", 32'(ringing), 32'd0);
    chk("rst_snz_ring_ch", 32'(ring_ch), 32'd0);
    chk("rst_snz_sec_tick", 32'(sec_tick), 32'd0);
    chk("rst_snz_chime", 32'(chime), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(SNOOZE_MIN * 60 + 1);
    chk("rst_snz_no_ring", 32'(ringing), 32'd0);
    chk("rst_snz_ch_idle", 32'(ring_ch), 32'd0);
    $display("reset in snooze: ringing=%b time=%h", ringing, time_bcd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
